// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// State encoding is fixed so waveforms and debug probes stay stable.
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam int REG_ADDR_W      = 5;
   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int CNT_W_DEF       = 16;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard sources in,
// stage enables / flushes / status out.
interface hazard_ctrl_if #(
   parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
   parameter int CNT_W      = hazard_pkg::CNT_W_DEF
);
   logic [REG_ADDR_W-1:0] if_id_rs;
   logic [REG_ADDR_W-1:0] if_id_rt;
   logic                  id_ex_memread;
   logic [REG_ADDR_W-1:0] id_ex_rt;
   logic                  ex_mem_branch;
   logic                  ex_mem_zero;
   logic                  mem_req;
   logic                  mem_ready;
   logic                  pc_we;
   logic                  if_id_we;
   logic                  id_ex_we;
   logic                  ex_mem_we;
   logic                  mem_wb_we;
   logic                  if_id_flush;
   logic                  id_ex_flush;
   logic                  ex_mem_flush;
   logic                  branch_taken;
   logic                  err;
   logic [CNT_W-1:0]      stall_cnt;
   logic [CNT_W-1:0]      flush_cnt;

   modport master (
      output if_id_rs, if_id_rt, id_ex_memread, id_ex_rt,
             ex_mem_branch, ex_mem_zero, mem_req, mem_ready,
      input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, ex_mem_flush, branch_taken,
             err, stall_cnt, flush_cnt
   );

   modport slave (
      input  if_id_rs, if_id_rt, id_ex_memread, id_ex_rt,
             ex_mem_branch, ex_mem_zero, mem_req, mem_ready,
      output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
             if_id_flush, id_ex_flush, ex_mem_flush, branch_taken,
             err, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_q <= '0;
      end else if (inc && (r_q != '1)) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage core: load-use bubbles, taken-branch
// squash, memory-wait freeze with a bounded-wait trap, and stall/flush counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input logic         clk,
   input logic         reset,
   hazard_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_next;
   logic              r_err;
   logic              w_freeze;
   logic              w_take;
   logic              w_lu;
   logic              w_stall_inc;

   always_comb begin
      w_freeze = ((r_state == RUN) && bus.mem_req && !bus.mem_ready) ||
                 ((r_state == MEM_WAIT) && !bus.mem_ready) ||
                 (r_state == ERR);
      w_take   = !w_freeze && bus.ex_mem_branch && bus.ex_mem_zero;
      // A load into $0 never produces a value, so it cannot cause a hazard
      w_lu     = !w_freeze && !w_take && bus.id_ex_memread &&
                 (bus.id_ex_rt != '0) &&
                 ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
      w_stall_inc = (w_freeze || w_lu) && (r_state != ERR);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_next;
         if (r_state == ERR) begin
            r_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_wait_next  = r_wait_cnt;
      case (r_state)
         RUN: begin
            if (bus.mem_req && !bus.mem_ready) begin
               w_state_next = MEM_WAIT;
               w_wait_next  = WAIT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               w_state_next = RUN;
               w_wait_next  = '0;
            end else if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
               w_state_next = ERR;
            end else begin
               w_wait_next = r_wait_cnt + WAIT_W'(1);
            end
         end
         ERR:     w_state_next = ERR;
         default: w_state_next = RUN;
      endcase
   end

   always_comb begin
      bus.pc_we        = 1'b1;
      bus.if_id_we     = 1'b1;
      bus.id_ex_we     = 1'b1;
      bus.ex_mem_we    = 1'b1;
      bus.mem_wb_we    = 1'b1;
      bus.if_id_flush  = 1'b0;
      bus.id_ex_flush  = 1'b0;
      bus.ex_mem_flush = 1'b0;
      bus.branch_taken = 1'b0;
      if (!reset) begin
         // Bubbles into every stage while held in reset
         bus.pc_we        = 1'b0;
         bus.if_id_we     = 1'b0;
         bus.id_ex_we     = 1'b0;
         bus.ex_mem_we    = 1'b0;
         bus.mem_wb_we    = 1'b0;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_flush  = 1'b1;
         bus.ex_mem_flush = 1'b1;
      end else if (w_freeze) begin
         bus.pc_we     = 1'b0;
         bus.if_id_we  = 1'b0;
         bus.id_ex_we  = 1'b0;
         bus.ex_mem_we = 1'b0;
         bus.mem_wb_we = 1'b0;
      end else if (w_take) begin
         bus.branch_taken = 1'b1;
         bus.if_id_flush  = 1'b1;
         bus.id_ex_flush  = 1'b1;
         bus.ex_mem_flush = 1'b1;
      end else if (w_lu) begin
         bus.pc_we       = 1'b0;
         bus.if_id_we    = 1'b0;
         bus.id_ex_flush = 1'b1;
      end
   end

   assign bus.err = r_err;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_stall_inc),
      .q     (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_take),
      .q     (bus.flush_cnt)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one task per scenario, inline checks.
module tb_hazard_ctrl;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
   //  if_id_flush, id_ex_flush, ex_mem_flush, branch_taken}
   localparam logic [8:0] RST_O  = 9'b00000_111_0;
   localparam logic [8:0] NORM_O = 9'b11111_000_0;
   localparam logic [8:0] FRZ_O  = 9'b00000_000_0;
   localparam logic [8:0] TAKE_O = 9'b11111_111_1;
   localparam logic [8:0] LU_O   = 9'b00111_010_0;

   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hif ();
   hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  sif ();

   hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (hif)
   );

   hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] outs();
      return {hif.pc_we, hif.if_id_we, hif.id_ex_we, hif.ex_mem_we, hif.mem_wb_we,
              hif.if_id_flush, hif.id_ex_flush, hif.ex_mem_flush, hif.branch_taken};
   endfunction

   // One transaction: apply inputs on the falling edge, let the Mealy outputs settle
   task automatic step(input logic rst, input logic memread, input logic [4:0] ex_rt,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic zr, input logic req, input logic rdy);
      @(negedge clk);
      reset             = rst;
      hif.id_ex_memread = memread;
      hif.id_ex_rt      = ex_rt;
      hif.if_id_rs      = rs;
      hif.if_id_rt      = rt;
      hif.ex_mem_branch = br;
      hif.ex_mem_zero   = zr;
      hif.mem_req       = req;
      hif.mem_ready     = rdy;
      #1;
      $display("[%0t] rst=%b ld=%b ex_rt=%0d rs=%0d rt=%0d br=%b z=%b req=%b rdy=%b -> outs=%b err=%b stall=%0d flush=%0d",
               $time, rst, memread, ex_rt, rs, rt, br, zr, req, rdy, outs(), hif.err,
               hif.stall_cnt, hif.flush_cnt);
   endtask

   task automatic test_reset();
      step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== RST_O) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs(), RST_O); end
      total++; if (hif.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", hif.err); end
      total++; if (hif.stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", hif.stall_cnt); end
      total++; if (hif.flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_flush got=%0d exp=0", hif.flush_cnt); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL idle_outs got=%b exp=%b", outs(), NORM_O); end
   endtask

   task automatic test_load_use();
      step(1'b1, 1, 5'd2, 5'd2, 5'd4, 0, 0, 0, 1);
      total++; if (outs() !== LU_O) begin bad++; $display("FAIL lu_rs_outs got=%b exp=%b", outs(), LU_O); end
      step(1'b1, 0, 5'd3, 5'd5, 5'd6, 0, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL lu_clear_outs got=%b exp=%b", outs(), NORM_O); end
      total++; if (hif.stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=1", hif.stall_cnt); end
      step(1'b1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 1);
      total++; if (outs() !== LU_O) begin bad++; $display("FAIL lu_rt_outs got=%b exp=%b", outs(), LU_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (hif.stall_cnt !== 16'd2) begin bad++; $display("FAIL lu_rt_stall got=%0d exp=2", hif.stall_cnt); end
   endtask

   task automatic test_zero_dest();
      step(1'b1, 1, 5'd0, 5'd0, 5'd3, 0, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL zero_dest_outs got=%b exp=%b", outs(), NORM_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (hif.stall_cnt !== 16'd2) begin bad++; $display("FAIL zero_dest_stall got=%0d exp=2", hif.stall_cnt); end
   endtask

   task automatic test_branch();
      step(1'b1, 1, 5'd2, 5'd2, 5'd2, 1, 1, 0, 1);
      total++; if (outs() !== TAKE_O) begin bad++; $display("FAIL take_outs got=%b exp=%b", outs(), TAKE_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (hif.flush_cnt !== 16'd1) begin bad++; $display("FAIL take_flush got=%0d exp=1", hif.flush_cnt); end
      total++; if (hif.stall_cnt !== 16'd2) begin bad++; $display("FAIL take_stall got=%0d exp=2", hif.stall_cnt); end
      step(1'b1, 0, 0, 0, 0, 1, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL not_taken_outs got=%b exp=%b", outs(), NORM_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (hif.flush_cnt !== 16'd1) begin bad++; $display("FAIL not_taken_flush got=%0d exp=1", hif.flush_cnt); end
   endtask

   // Branch sits in EX/MEM during the wait and must resolve on the release cycle
   task automatic test_mem_wait();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 0, 0, 0, 0, 1, 1, 1, 0);
         total++; if (outs() !== FRZ_O) begin bad++; $display("FAIL wait_freeze[%0d] got=%b exp=%b", i, outs(), FRZ_O); end
      end
      step(1'b1, 0, 0, 0, 0, 1, 1, 1, 1);
      total++; if (outs() !== TAKE_O) begin bad++; $display("FAIL wait_release got=%b exp=%b", outs(), TAKE_O); end
      total++; if (hif.stall_cnt !== 16'd6) begin bad++; $display("FAIL wait_stall got=%0d exp=6", hif.stall_cnt); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL wait_back_to_run got=%b exp=%b", outs(), NORM_O); end
      total++; if (hif.flush_cnt !== 16'd2) begin bad++; $display("FAIL wait_flush got=%0d exp=2", hif.flush_cnt); end
   endtask

   task automatic test_zero_latency();
      step(1'b1, 0, 0, 0, 0, 0, 0, 1, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL zero_lat_outs got=%b exp=%b", outs(), NORM_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL zero_lat_next got=%b exp=%b", outs(), NORM_O); end
      total++; if (hif.stall_cnt !== 16'd6) begin bad++; $display("FAIL zero_lat_stall got=%0d exp=6", hif.stall_cnt); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
         total++; if (outs() !== FRZ_O) begin bad++; $display("FAIL to_freeze[%0d] got=%b exp=%b", i, outs(), FRZ_O); end
      end
      step(1'b1, 0, 0, 0, 0, 0, 0, 1, 1);
      total++; if (outs() !== FRZ_O) begin bad++; $display("FAIL err_state_outs got=%b exp=%b", outs(), FRZ_O); end
      total++; if (hif.err !== 1'b0) begin bad++; $display("FAIL err_not_yet got=%b exp=0", hif.err); end
      total++; if (hif.stall_cnt !== 16'd22) begin bad++; $display("FAIL to_stall got=%0d exp=22", hif.stall_cnt); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== FRZ_O) begin bad++; $display("FAIL err_stuck got=%b exp=%b", outs(), FRZ_O); end
      total++; if (hif.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", hif.err); end
      total++; if (hif.stall_cnt !== 16'd22) begin bad++; $display("FAIL err_no_count got=%0d exp=22", hif.stall_cnt); end
      step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== RST_O) begin bad++; $display("FAIL err_reset_outs got=%b exp=%b", outs(), RST_O); end
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      total++; if (outs() !== NORM_O) begin bad++; $display("FAIL err_recover_outs got=%b exp=%b", outs(), NORM_O); end
      total++; if (hif.err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", hif.err); end
      total++; if (hif.stall_cnt !== 16'd0) begin bad++; $display("FAIL err_stall_cleared got=%0d exp=0", hif.stall_cnt); end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      sif.id_ex_memread = 1'b1;
      sif.id_ex_rt      = 5'd2;
      sif.if_id_rs      = 5'd2;
      repeat (10) @(negedge clk);
      $display("[%0t] sat after 10 lu cycles stall=%0d", $time, sif.stall_cnt);
      total++; if (sif.stall_cnt !== 4'd10) begin bad++; $display("FAIL sat_mid got=%0d exp=10", sif.stall_cnt); end
      repeat (10) @(negedge clk);
      $display("[%0t] sat after 20 lu cycles stall=%0d", $time, sif.stall_cnt);
      total++; if (sif.stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_end got=%0d exp=15", sif.stall_cnt); end
      total++; if (sif.pc_we !== 1'b0) begin bad++; $display("FAIL sat_lu_pc_we got=%b exp=0", sif.pc_we); end
      sif.id_ex_memread = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      hif.id_ex_memread = 1'b0; hif.id_ex_rt = '0; hif.if_id_rs = '0; hif.if_id_rt = '0;
      hif.ex_mem_branch = 1'b0; hif.ex_mem_zero = 1'b0; hif.mem_req = 1'b0; hif.mem_ready = 1'b1;
      sif.id_ex_memread = 1'b0; sif.id_ex_rt = '0; sif.if_id_rs = '0; sif.if_id_rt = '0;
      sif.ex_mem_branch = 1'b0; sif.ex_mem_zero = 1'b0; sif.mem_req = 1'b0; sif.mem_ready = 1'b1;

      test_reset();
      test_load_use();
      test_zero_dest();
      test_branch();
      test_mem_wait();
      test_zero_latency();
      test_timeout();
      test_saturation();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS32 core. Detects load-use hazards, flushes wrong-path instructions on a taken branch resolved in MEM, and freezes the whole pipeline while a variable-latency data memory access is pending, with a bounded-wait error trap. It drives the write enables and flush inputs added to PC, IF_ID, ID_EX and EX_MEM, and keeps two saturating performance counters.

## Interface
- Clock `clk`; reset `reset`: synchronous, active-low.
- `REG_ADDR_W`, default 5: register address width.
- `MEM_TIMEOUT`, default 15: maximum wait cycles before the error trap.
- `CNT_W`, default 16: width of the performance counters.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-low.
- `if_id_rs`  in  REG_ADDR_W  rs field of the instruction in IF/ID.
- `if_id_rt`  in  REG_ADDR_W  rt field of the instruction in IF/ID.
- `id_ex_memread`  in  1  MemRead of the instruction in ID/EX.
- `id_ex_rt`  in  REG_ADDR_W  rt (load destination) of the instruction in ID/EX.
- `ex_mem_branch`  in  1  Branch control bit in EX/MEM.
- `ex_mem_zero`  in  1  ALU zero flag in EX/MEM.
- `mem_req`  in  1  MemRead or MemWrite in EX/MEM.
- `mem_ready`  in  1  data memory has completed the access this cycle.
- `pc_we`  out  1  PC load enable.
- `if_id_we`  out  1  IF/ID load enable.
- `id_ex_we`, `ex_mem_we`, `mem_wb_we`  out  1 each  stage load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  load zeros (bubble) into the stage.
- `branch_taken`  out  1  selects the branch target at the PC mux.
- `err`  out  1  memory timeout trap, sticky.
- `stall_cnt`  out  CNT_W  cycles lost to stalls.
- `flush_cnt`  out  CNT_W  taken branches.

## Operation
- States: RUN, MEM_WAIT, ERR. `wait_cnt` is a register of width clog2(MEM_TIMEOUT+1).
- freeze = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready) | ERR.
- take = !freeze & ex_mem_branch & ex_mem_zero.
- lu = !freeze & !take & id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- freeze: all `*_we` = 0, all flushes = 0, `branch_taken` = 0.
- take: `branch_taken` = 1, `pc_we` = 1, all stage enables = 1, and `if_id_flush`, `id_ex_flush`, `ex_mem_flush` = 1. This squashes the three wrong-path instructions. Any coincident load-use is discarded.
- lu: `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1, remaining enables = 1. This inserts one bubble; the hazard clears the next cycle because the load has moved to EX/MEM.
- Otherwise: all enables = 1, all flushes = 0.
- State transitions:
  - RUN to MEM_WAIT on mem_req & !mem_ready, with `wait_cnt` = 1.
  - MEM_WAIT to RUN on mem_ready. That cycle is evaluated as unfrozen, so take and lu apply.
  - In MEM_WAIT with !mem_ready, `wait_cnt` increments.
  - MEM_WAIT to ERR when `wait_cnt` == MEM_TIMEOUT and !mem_ready.
  - ERR is left only by reset.
- A zero-latency memory (mem_ready high in the same cycle as mem_req) never stalls.
- `stall_cnt` increments in every cycle where freeze or lu is true outside ERR. `flush_cnt` increments on take. Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Enables and flushes are Mealy outputs: combinational from the current state and inputs, with no added latency. They must settle before the rising edge of `clk`.
- While `reset` = 0:
  - Next state is RUN; `wait_cnt`, `err`, `stall_cnt`, `flush_cnt` go to 0.
  - Outputs are forced to `pc_we` = 0, all stage enables = 0, all flushes = 1, `branch_taken` = 0, which clears the pipeline.
- A reset applied during MEM_WAIT or ERR takes effect at the next edge.
- `err` rises in the cycle after the timeout, registered from the ERR state.
- A branch sitting in EX/MEM during a freeze is held and resolved in the first unfrozen cycle.

## Structure
- Shared package `hazard_pkg` holds:
  - the state enum (RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2);
  - REG_ADDR_W;
  - the default MEM_TIMEOUT.
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `q`), instantiated twice.

## Test plan
- Load-use: `lw $2` in ID/EX, `add $3,$2,$4` in IF/ID, mem_ready = 1. Required: for exactly one cycle `pc_we` = 0, `if_id_we` = 0, `id_ex_flush` = 1; `stall_cnt` = 1.
- Destination $0: `id_ex_rt` = 0 matching `if_id_rs` = 0. Required: no stall.
- Taken branch: `ex_mem_branch` = 1 and `ex_mem_zero` = 1, together with a load-use match. Required: `branch_taken` = 1, all three flushes = 1, no bubble; `flush_cnt` = 1.
- Memory wait: mem_req = 1 with mem_ready low for 4 cycles, then high. Required: all enables = 0 for 4 cycles, enables = 1 in the 5th; `stall_cnt` = 4; state is RUN afterwards.
- Timeout: mem_ready held low. Required: ERR after MEM_TIMEOUT cycles, `err` = 1 and the pipeline stays frozen; `reset` = 0 for one cycle restores RUN with `err` = 0.
- Saturation: force CNT_W = 4 and run 20 stall cycles. Required: `stall_cnt` = 15.
